// File: rtl/regs_wport_arb.sv
// rtl/regs_wport_arb.sv - register-file write-port arbiter between pipeline writeback and buffered long-latency results
//
// Purpose:
//   Shares the single register-file write port between the pipeline writeback
//   stream (WB) and long-latency unit results (LU). LU results wait in a small
//   FIFO. WB normally wins the port. A starve counter forces one buffered LU
//   write after STARVE_MAX consecutive WB grants. While that forced write
//   happens, the pipeline is stalled. A pending scoreboard tracks issued LU
//   destinations so that readers can detect RAW hazards.
//
// Ports:
//   clk_i, rst_ni                        clock, asynchronous active-low reset
//   wb_valid_i/wb_addr_i/wb_data_i       pipeline writeback request (addr 0 = none)
//   lu_valid_i/lu_addr_i/lu_data_i       LU result offer
//   lu_ready_o                           LU buffer can accept this cycle
//   iss_valid_i/iss_addr_i               LU instruction issued; marks destination pending
//   rd_addr_a_i/rd_addr_b_i              read addresses checked for hazards
//   hazard_a_o/hazard_b_o                read address has a pending LU write
//   rf_we_o/rf_waddr_o/rf_wdata_o        register-file write port
//   wb_stall_o                           pipeline must hold and re-present WB
//   busy_o                               buffer non-empty or any register pending

module regs_wport_arb #(
    parameter int DEPTH      = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        wb_valid_i,
    input  logic [4:0]  wb_addr_i,
    input  logic [31:0] wb_data_i,
    input  logic        lu_valid_i,
    input  logic [4:0]  lu_addr_i,
    input  logic [31:0] lu_data_i,
    output logic        lu_ready_o,
    input  logic        iss_valid_i,
    input  logic [4:0]  iss_addr_i,
    input  logic [4:0]  rd_addr_a_i,
    input  logic [4:0]  rd_addr_b_i,
    output logic        hazard_a_o,
    output logic        hazard_b_o,
    output logic        rf_we_o,
    output logic [4:0]  rf_waddr_o,
    output logic [31:0] rf_wdata_o,
    output logic        wb_stall_o,
    output logic        busy_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam int ST_W  = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;

    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
    localparam logic [ST_W-1:0]  STARVE_C = ST_W'(STARVE_MAX);

    // LU result buffer storage; contents need no reset because count_q
    // governs which entries are meaningful.
    logic [4:0]       buf_addr_q [DEPTH];
    logic [31:0]      buf_data_q [DEPTH];

    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [ST_W-1:0]  starve_q, starve_d;
    logic [31:0]      pending_q, pending_d;

    logic        has_entry;
    logic        wb_req;
    logic        grant_head;
    logic        grant_wb;
    logic        push;
    logic        pop;
    logic [4:0]  head_addr;
    logic [31:0] head_data;

    assign head_addr = buf_addr_q[head_q];
    assign head_data = buf_data_q[head_q];
    assign has_entry = (count_q != '0);

    // A writeback to r0 is dropped entirely and does not compete for the port.
    assign wb_req = wb_valid_i && (wb_addr_i != 5'd0);

    // lu_ready comes from registered count only. A full buffer stays not-ready
    // even in a cycle where it pops, which keeps lu_ready off the grant path.
    assign lu_ready_o = (count_q < DEPTH_C);

    assign wb_stall_o = (starve_q == STARVE_C) && has_entry;

    // Port priority: forced head on stall, then WB, then any buffered head.
    assign grant_head = wb_stall_o || (!wb_req && has_entry);
    assign grant_wb   = !wb_stall_o && wb_req;

    assign push = lu_valid_i && lu_ready_o;
    assign pop  = grant_head;

    always_comb begin
        rf_we_o    = 1'b0;
        rf_waddr_o = 5'd0;
        rf_wdata_o = 32'd0;
        if (grant_head) begin
            // A head entry for r0 still consumes its slot but never writes.
            rf_we_o    = (head_addr != 5'd0);
            rf_waddr_o = head_addr;
            rf_wdata_o = head_data;
        end else if (grant_wb) begin
            rf_we_o    = 1'b1;
            rf_waddr_o = wb_addr_i;
            rf_wdata_o = wb_data_i;
        end
    end

    // Pointer, occupancy and starve next-state.
    always_comb begin
        head_d   = head_q;
        tail_d   = tail_q;
        count_d  = count_q;
        starve_d = starve_q;

        if (push) begin
            tail_d = tail_q + PTR_W'(1);
        end
        if (pop) begin
            head_d = head_q + PTR_W'(1);
        end

        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        // Starvation only accrues while something is actually waiting.
        if (grant_head || !has_entry) begin
            starve_d = '0;
        end else if (grant_wb && (starve_q < STARVE_C)) begin
            starve_d = starve_q + ST_W'(1);
        end
    end

    // Pending scoreboard: the clear from a head pop is applied first so that
    // a same-cycle issue to that register leaves it pending.
    always_comb begin
        pending_d = pending_q;
        if (pop && (head_addr != 5'd0)) begin
            pending_d[head_addr] = 1'b0;
        end
        if (iss_valid_i && (iss_addr_i != 5'd0)) begin
            pending_d[iss_addr_i] = 1'b1;
        end
        pending_d[0] = 1'b0;
    end

    // Hazards look at registered state only; a clear happening this cycle is
    // not bypassed.
    assign hazard_a_o = (rd_addr_a_i != 5'd0) && pending_q[rd_addr_a_i];
    assign hazard_b_o = (rd_addr_b_i != 5'd0) && pending_q[rd_addr_b_i];

    assign busy_o = has_entry || (|pending_q);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            head_q    <= '0;
            tail_q    <= '0;
            count_q   <= '0;
            starve_q  <= '0;
            pending_q <= '0;
        end else begin
            head_q    <= head_d;
            tail_q    <= tail_d;
            count_q   <= count_d;
            starve_q  <= starve_d;
            pending_q <= pending_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            buf_addr_q[tail_q] <= lu_addr_i;
            buf_data_q[tail_q] <= lu_data_i;
        end
    end

endmodule

// File: tb/tb_regs_wport_arb.sv
// tb/tb_regs_wport_arb.sv - scoreboard testbench for regs_wport_arb

module tb_regs_wport_arb;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wb_valid;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        lu_valid;
    logic [4:0]  lu_addr;
    logic [31:0] lu_data;
    logic        lu_ready;
    logic        iss_valid;
    logic [4:0]  iss_addr;
    logic [4:0]  rd_a;
    logic [4:0]  rd_b;
    logic        hazard_a;
    logic        hazard_b;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        wb_stall;
    logic        busy;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [36:0] exp_q[$];
    logic [36:0] mon_e;
    int          k;
    logic        st;
    logic        rdy;

    regs_wport_arb #(.DEPTH(2), .STARVE_MAX(4)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .wb_valid_i  (wb_valid),
        .wb_addr_i   (wb_addr),
        .wb_data_i   (wb_data),
        .lu_valid_i  (lu_valid),
        .lu_addr_i   (lu_addr),
        .lu_data_i   (lu_data),
        .lu_ready_o  (lu_ready),
        .iss_valid_i (iss_valid),
        .iss_addr_i  (iss_addr),
        .rd_addr_a_i (rd_a),
        .rd_addr_b_i (rd_b),
        .hazard_a_o  (hazard_a),
        .hazard_b_o  (hazard_b),
        .rf_we_o     (rf_we),
        .rf_waddr_o  (rf_waddr),
        .rf_wdata_o  (rf_wdata),
        .wb_stall_o  (wb_stall),
        .busy_o      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Write-port monitor: every register-file write must match the next
    // expected entry, in order.
    always @(negedge clk) begin
        if (rf_we !== 1'b0) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_write: got addr %0d data %0h we %b, expected no write",
                         rf_waddr, rf_wdata, rf_we);
            end else begin
                mon_e = exp_q.pop_front();
                if ({rf_waddr, rf_wdata} !== mon_e) begin
                    n_fail++;
                    $display("FAIL write_order: got addr %0d data %0h expected addr %0d data %0h",
                             rf_waddr, rf_wdata, mon_e[36:32], mon_e[31:0]);
                end
            end
        end
    end

    task automatic idle_inputs();
        wb_valid  = 1'b0;
        wb_addr   = 5'd0;
        wb_data   = 32'd0;
        lu_valid  = 1'b0;
        lu_addr   = 5'd0;
        lu_data   = 32'd0;
        iss_valid = 1'b0;
        iss_addr  = 5'd0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        idle_inputs();
        rd_a = 5'd2;
        rd_b = 5'd7;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Reset state
        chk("rst_rf_we", rf_we, 0);
        chk("rst_rf_waddr", rf_waddr, 0);
        chk("rst_rf_wdata", rf_wdata, 0);
        chk("rst_lu_ready", lu_ready, 1);
        chk("rst_wb_stall", wb_stall, 0);
        chk("rst_busy", busy, 0);
        chk("rst_hazard_a", hazard_a, 0);
        chk("rst_hazard_b", hazard_b, 0);
        rst_n = 1'b1;
        tick();

        // WB only: r5 <= 0x1234 in the same cycle
        exp_q.push_back({5'd5, 32'h1234});
        wb_valid = 1'b1; wb_addr = 5'd5; wb_data = 32'h1234;
        @(negedge clk);
        chk("wb_only_lu_ready", lu_ready, 1);
        chk("wb_only_busy", busy, 0);
        tick();
        // WB to r0 is no request
        wb_addr = 5'd0; wb_data = 32'hDEAD;
        @(negedge clk);
        chk("wb_r0_busy", busy, 0);
        tick();
        idle_inputs();

        // Issue r7, later LU result for r7
        rd_a = 5'd7;
        rd_b = 5'd7;
        iss_valid = 1'b1; iss_addr = 5'd7;
        @(negedge clk);
        chk("hz7_issue_cycle", hazard_a, 0);
        tick();
        iss_valid = 1'b0;
        @(negedge clk);
        chk("hz7_after_issue", hazard_a, 1);
        chk("hz7_b_after_issue", hazard_b, 1);
        chk("busy_pending7", busy, 1);
        tick();
        lu_valid = 1'b1; lu_addr = 5'd7; lu_data = 32'hAA;
        @(negedge clk);
        chk("lu7_ready", lu_ready, 1);
        tick();
        lu_valid = 1'b0;
        exp_q.push_back({5'd7, 32'hAA});
        @(negedge clk);
        chk("hz7_write_cycle", hazard_a, 1);
        tick();
        @(negedge clk);
        chk("hz7_cleared", hazard_a, 0);
        chk("busy_after_lu7", busy, 0);
        tick();

        // Starvation: two LU entries against continuous WB
        for (int i = 0; i <= 8; i++) begin
            if (i == 5) exp_q.push_back({5'd3, 32'h11});
            exp_q.push_back({5'(16 + (i % 8)), 32'h100 + 32'(i)});
        end
        exp_q.push_back({5'd4, 32'h22});
        k = 0;
        for (int c = 0; c <= 10; c++) begin
            st = (c == 5) || (c == 10);
            wb_valid = 1'b1;
            wb_addr  = 5'(16 + (k % 8));
            wb_data  = 32'h100 + 32'(k);
            lu_valid = (c < 2);
            lu_addr  = (c == 0) ? 5'd3 : 5'd4;
            lu_data  = (c == 0) ? 32'h11 : 32'h22;
            @(negedge clk);
            chk($sformatf("starve_stall_c%0d", c), wb_stall, st);
            if (c < 2) chk($sformatf("starve_lu_ready_c%0d", c), lu_ready, 1);
            tick();
            if (!st) k++;
        end
        idle_inputs();
        @(negedge clk);
        chk("starve_done_busy", busy, 0);
        tick();

        // Buffer full with lu_valid held
        for (int i = 0; i <= 5; i++) begin
            if (i == 5) exp_q.push_back({5'd1, 32'hA1});
            exp_q.push_back({5'(16 + (i % 8)), 32'h200 + 32'(i)});
        end
        exp_q.push_back({5'd2, 32'hA2});
        exp_q.push_back({5'd5, 32'hA5});
        k = 0;
        for (int c = 0; c <= 6; c++) begin
            st  = (c == 5);
            rdy = !((c >= 2) && (c <= 5));
            wb_valid = 1'b1;
            wb_addr  = 5'(16 + (k % 8));
            wb_data  = 32'h200 + 32'(k);
            lu_valid = 1'b1;
            lu_addr  = (c == 0) ? 5'd1 : ((c == 1) ? 5'd2 : 5'd5);
            lu_data  = (c == 0) ? 32'hA1 : ((c == 1) ? 32'hA2 : 32'hA5);
            @(negedge clk);
            chk($sformatf("full_lu_ready_c%0d", c), lu_ready, rdy);
            chk($sformatf("full_stall_c%0d", c), wb_stall, st);
            tick();
            if (!st) k++;
        end
        idle_inputs();
        repeat (3) tick();
        @(negedge clk);
        chk("full_drained_busy", busy, 0);
        tick();

        // Issue r9 in the same cycle its head entry pops
        rd_a = 5'd9;
        iss_valid = 1'b1; iss_addr = 5'd9;
        tick();
        iss_valid = 1'b0;
        lu_valid = 1'b1; lu_addr = 5'd9; lu_data = 32'h99;
        exp_q.push_back({5'd9, 32'h99});
        tick();
        lu_valid = 1'b0;
        iss_valid = 1'b1; iss_addr = 5'd9;
        @(negedge clk);
        chk("r9_pop_cycle_hazard", hazard_a, 1);
        tick();
        iss_valid = 1'b0;
        @(negedge clk);
        chk("r9_set_wins", hazard_a, 1);
        chk("r9_busy", busy, 1);
        tick();
        lu_valid = 1'b1; lu_addr = 5'd9; lu_data = 32'h9A;
        exp_q.push_back({5'd9, 32'h9A});
        tick();
        lu_valid = 1'b0;
        tick();
        @(negedge clk);
        chk("r9_cleared", hazard_a, 0);
        chk("r9_busy_clear", busy, 0);
        tick();

        // Reset with two buffered entries and r2 pending
        rd_a = 5'd2;
        iss_valid = 1'b1; iss_addr = 5'd2;
        lu_valid = 1'b1; lu_addr = 5'd6; lu_data = 32'hB6;
        wb_valid = 1'b1; wb_addr = 5'd20; wb_data = 32'hC0;
        exp_q.push_back({5'd20, 32'hC0});
        tick();
        iss_valid = 1'b0;
        lu_addr = 5'd8; lu_data = 32'hB8;
        wb_addr = 5'd21; wb_data = 32'hC1;
        exp_q.push_back({5'd21, 32'hC1});
        @(negedge clk);
        chk("rst_setup_lu_ready", lu_ready, 1);
        tick();
        idle_inputs();
        chk("pre_rst_full", lu_ready, 0);
        chk("pre_rst_hazard2", hazard_a, 1);
        rst_n = 1'b0;
        #1;
        chk("in_rst_lu_ready", lu_ready, 1);
        chk("in_rst_busy", busy, 0);
        chk("in_rst_hazard2", hazard_a, 0);
        chk("in_rst_rf_we", rf_we, 0);
        chk("in_rst_stall", wb_stall, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_busy", busy, 0);
        chk("post_rst_lu_ready", lu_ready, 1);
        chk("post_rst_hazard2", hazard_a, 0);
        chk("post_rst_rf_we", rf_we, 0);
        repeat (3) tick();

        chk("scoreboard_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
